// File: rtl/interrupt_ack_sequencer.sv
// INTA acknowledge sequencer for the 8-level interrupt controller: owns isr and priority_rotate.
// Optional auto-EOI on ACK2 is enabled with `define PIC_AEOI_EN (adds the aeoi input).
module interrupt_ack_sequencer #(
   parameter logic [2:0] RESET_ROTATE   = 3'd7,
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       inta,
   input  logic [4:0] vector_base,
   input  logic       eoi_valid,
   input  logic       eoi_specific,
   input  logic       eoi_rotate,
   input  logic [2:0] eoi_level,
   input  logic       setprio_valid,
   input  logic [2:0] setprio_level,
`ifdef PIC_AEOI_EN
   input  logic       aeoi,
`endif
   output logic       int_out,
   output logic [7:0] irr_clear,
   output logic [7:0] isr,
   output logic [2:0] priority_rotate,
   output logic [7:0] vector_out,
   output logic       vector_valid
);

   typedef enum logic {IDLE, WAIT_ACK2} state_t;

   state_t     state, state_nxt;
   logic [2:0] level, level_nxt;
   logic       spurious, spurious_nxt;
   logic       int_nxt, vv_nxt;
   logic [7:0] irr_nxt, isr_nxt, vo_nxt;
   logic [2:0] rot_nxt;
   logic       clr_hit;
   logic [2:0] clr_lvl, idx, enc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         level           <= 3'd0;
         spurious        <= 1'b0;
         int_out         <= 1'b0;
         irr_clear       <= 8'h00;
         isr             <= 8'h00;
         priority_rotate <= RESET_ROTATE;
         vector_out      <= 8'h00;
         vector_valid    <= 1'b0;
      end else begin
         state           <= state_nxt;
         level           <= level_nxt;
         spurious        <= spurious_nxt;
         int_out         <= int_nxt;
         irr_clear       <= irr_nxt;
         isr             <= isr_nxt;
         priority_rotate <= rot_nxt;
         vector_out      <= vo_nxt;
         vector_valid    <= vv_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      level_nxt    = level;
      spurious_nxt = spurious;
      int_nxt      = int_out;
      irr_nxt      = 8'h00;
      vv_nxt       = 1'b0;
      vo_nxt       = vector_out;
      isr_nxt      = isr;
      rot_nxt      = priority_rotate;
      clr_hit      = 1'b0;
      clr_lvl      = 3'd0;
      idx          = 3'd0;
      enc          = 3'd0;

      // EOI target is resolved against the isr before any ACK1 set this cycle
      if (eoi_valid) begin
         if (eoi_specific) begin
            clr_hit = isr[eoi_level];
            clr_lvl = eoi_level;
         end else begin
            for (int k = 1; k <= 8; k++) begin
               idx = priority_rotate + k[2:0];
               if (!clr_hit && isr[idx]) begin
                  clr_hit = 1'b1;
                  clr_lvl = idx;
               end
            end
         end
      end
      if (clr_hit) isr_nxt[clr_lvl] = 1'b0;

      if (eoi_valid && eoi_rotate && clr_hit) rot_nxt = clr_lvl;
      else if (setprio_valid)                 rot_nxt = setprio_level;

      for (int i = 0; i < 8; i++)
         if (interrupt[i]) enc = i[2:0];

      case (state)
         IDLE: begin
            if (inta && int_out) begin
               int_nxt   = 1'b0;
               state_nxt = WAIT_ACK2;
               if (interrupt != 8'h00) begin
                  level_nxt      = enc;
                  spurious_nxt   = 1'b0;
                  isr_nxt[enc]   = 1'b1;
                  irr_nxt        = interrupt;
               end else begin
                  level_nxt    = SPURIOUS_LEVEL;
                  spurious_nxt = 1'b1;
               end
            end else begin
               int_nxt = |interrupt;
            end
         end
         WAIT_ACK2: begin
            int_nxt = 1'b0;
            if (inta) begin
               vo_nxt    = {vector_base, level};
               vv_nxt    = 1'b1;
               state_nxt = IDLE;
`ifdef PIC_AEOI_EN
               // a spurious ack never set a bit, so there is nothing to auto-clear
               if (aeoi && !spurious) isr_nxt[level] = 1'b0;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
